// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_pkg
//  Description : Shared definitions for the two-requester memory bus arbiter.
//                Holds the FSM state codes, the bus direction codes, the
//                default bus widths and the round-robin pick helper.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_arbiter_pkg;

    // Default widths of the shared memory bus.
    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 8;

    // Width of the burst counter. It covers the full MAX_BURST range of 0..255.
    localparam int c_BURST_W = 8;

    // Arbiter state codes (2-bit encoding).
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_OWN0     = 2'd1;
    localparam logic [1:0] c_ST_OWN1     = 2'd2;
    localparam logic [1:0] c_ST_HANDOVER = 2'd3;

    // Bus direction codes.
    localparam logic c_RW_READ  = 1'b0;
    localparam logic c_RW_WRITE = 1'b1;

    // Round-robin pick between the two requesters.
    // If both request, the one that did not own the bus last wins.
    // If only one requests, that one wins.
    // The result is meaningless when nobody requests, and callers gate on that.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        return (req0 && req1) ? ~last : req1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-requester arbiter for the shared memory bus.
//                Requester 0 is the CPU core and requester 1 the DMA master.
//                The arbiter applies round-robin on ties and bounded-burst
//                preemption, and it inserts one dead cycle on every owner
//                switch. The owner's addr/rw/wdata are muxed onto the memory
//                side.
//  Ports       : clk                          system clock (posedge)
//                rst                          asynchronous reset, active-low
//                rN_req/addr/rw/wdata         requester N request and bus fields
//                rN_gnt                       requester N owns the bus this cycle
//                mem_addr/mem_rw/mem_wdata    shared memory-side bus
//                mem_rdata                    read data from memory
//                rdata                        mem_rdata broadcast to requesters
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W,
    parameter int DATA_W    = c_DATA_W,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r0_rw,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic              r1_rw,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata
);

    // MAX_BURST of 0 disables preemption entirely.
    localparam logic                 c_PREEMPT_EN = (MAX_BURST != 0);
    localparam logic [c_BURST_W-1:0] c_BURST_LAST =
        (MAX_BURST == 0) ? '0 : c_BURST_W'(MAX_BURST - 1);
    localparam logic [c_BURST_W-1:0] c_BURST_SAT  = '1;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_last;       // 0/1 = last requester that owned the bus
    logic                 w_last_nxt;
    logic [c_BURST_W-1:0] r_burst;      // contested cycles in the current ownership
    logic [c_BURST_W-1:0] w_burst_nxt;

    logic w_pick;
    logic w_own_req;
    logic w_oth_req;

    assign w_pick    = rr_pick(r0_req, r1_req, r_last);
    assign w_own_req = (r_state == c_ST_OWN1) ? r1_req : r0_req;
    assign w_oth_req = (r_state == c_ST_OWN1) ? r0_req : r1_req;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_last  <= 1'b1;          // r0 wins the first tie
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_burst_nxt = r_burst;
        case (r_state)
            // IDLE and HANDOVER share the same pick rule. After a handover
            // r_last still names the outgoing owner. The other side therefore
            // wins when it requests, and the old owner wins only when it is
            // the sole requester.
            c_ST_IDLE, c_ST_HANDOVER: begin
                if (r0_req || r1_req) begin
                    w_state_nxt = w_pick ? c_ST_OWN1 : c_ST_OWN0;
                    w_last_nxt  = w_pick;
                    w_burst_nxt = '0;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_OWN0, c_ST_OWN1: begin
                if (!w_own_req) begin
                    w_state_nxt = w_oth_req ? c_ST_HANDOVER : c_ST_IDLE;
                end else if (w_oth_req && c_PREEMPT_EN && (r_burst == c_BURST_LAST)) begin
                    w_state_nxt = c_ST_HANDOVER;
                end else if (w_oth_req && (r_burst != c_BURST_SAT)) begin
                    // Count only the cycles in which someone is waiting.
                    w_burst_nxt = r_burst + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: grants decode the state register, and the memory side is a
    // plain mux of the owner's inputs. Because this is combinational,
    // mem_rw drops as soon as the asynchronous reset clears r_state.
    // ------------------------------------------------------------------
    assign r0_gnt = (r_state == c_ST_OWN0);
    assign r1_gnt = (r_state == c_ST_OWN1);
    assign rdata  = mem_rdata;

    always_comb begin
        mem_addr  = '0;
        mem_rw    = c_RW_READ;
        mem_wdata = '0;
        case (r_state)
            c_ST_OWN0: begin
                mem_addr  = r0_addr;
                mem_rw    = r0_rw;
                mem_wdata = r0_wdata;
            end
            c_ST_OWN1: begin
                mem_addr  = r1_addr;
                mem_rw    = r1_rw;
                mem_wdata = r1_wdata;
            end
            default: begin
                mem_addr  = '0;
                mem_rw    = c_RW_READ;
                mem_wdata = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
